// File: rtl/imm_encoder_if.sv
// rtl/imm_encoder_if.sv - request/response bundle for the immediate encoder
`ifndef EXT_OP_LENGTH
`define EXT_OP_LENGTH 3
`endif
`ifndef EXT_OP_I
`define EXT_OP_I 3'd0
`endif
`ifndef EXT_OP_U
`define EXT_OP_U 3'd1
`endif
`ifndef EXT_OP_S
`define EXT_OP_S 3'd2
`endif
`ifndef EXT_OP_B
`define EXT_OP_B 3'd3
`endif
`ifndef EXT_OP_J
`define EXT_OP_J 3'd4
`endif

interface imm_encoder_if;
    logic                      in_valid;
    logic                      in_ready;
    logic [`EXT_OP_LENGTH-1:0] ExtOp;
    logic [31:0]               Imm;
    logic [31:0]               Tmpl;
    logic                      out_valid;
    logic                      out_ready;
    logic [31:0]               Inst;
    logic                      Err;

    modport master (
        output in_valid, ExtOp, Imm, Tmpl, out_ready,
        input  in_ready, out_valid, Inst, Err
    );

    modport slave (
        input  in_valid, ExtOp, Imm, Tmpl, out_ready,
        output in_ready, out_valid, Inst, Err
    );
endinterface

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - packs an immediate into RISC-V I/S/B/U/J instruction fields
// Optional round-trip self check: IMM_ENC_ROUNDTRIP_CHECK_EN.
module imm_encoder #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    imm_encoder_if.slave         bus,
    output logic [CNT_WIDTH-1:0] enc_cnt,
    output logic [CNT_WIDTH-1:0] err_cnt
`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
    ,
    output logic                 rt_mismatch
`endif
);

    logic                 runQ;
    logic                 s1Valid;
    logic [31:0]          s1Field;
    logic [31:0]          s1Mask;
    logic [31:0]          s1Tmpl;
    logic                 s1Err;
    logic                 outValidQ;
    logic [31:0]          instQ;
    logic                 errQ;
    logic [CNT_WIDTH-1:0] encCntQ;
    logic [CNT_WIDTH-1:0] errCntQ;

    logic        accept;
    logic        s1Advance;
    logic        outXfer;
    logic [31:0] encField;
    logic [31:0] encMask;
    logic        encErr;
    logic        fits12;
    logic        fits13;
    logic        fits21;
    logic [31:0] s2Next;

    assign s1Advance    = s1Valid && (!outValidQ || bus.out_ready);
    assign bus.in_ready = runQ && (!s1Valid || s1Advance);
    assign accept       = bus.in_valid && bus.in_ready;
    assign outXfer      = outValidQ && bus.out_ready;

    // Signed range checks: every bit above the top field bit must equal the sign.
    assign fits12 = (bus.Imm[31:11] == '0) || (bus.Imm[31:11] == '1);
    assign fits13 = (bus.Imm[31:12] == '0) || (bus.Imm[31:12] == '1);
    assign fits21 = (bus.Imm[31:20] == '0) || (bus.Imm[31:20] == '1);

    always_comb begin
        encField = '0;
        encMask  = '0;
        encErr   = 1'b1;
        case (bus.ExtOp)
            `EXT_OP_I: begin
                encErr   = !fits12;
                encField = {bus.Imm[11:0], 20'b0};
                encMask  = 32'hFFF0_0000;
            end
            `EXT_OP_S: begin
                encErr   = !fits12;
                encField = {bus.Imm[11:5], 13'b0, bus.Imm[4:0], 7'b0};
                encMask  = 32'hFE00_0F80;
            end
            `EXT_OP_B: begin
                encErr   = !fits13 || bus.Imm[0];
                encField = {bus.Imm[12], bus.Imm[10:5], 13'b0,
                            bus.Imm[4:1], bus.Imm[11], 7'b0};
                encMask  = 32'hFE00_0F80;
            end
            `EXT_OP_U: begin
                encErr   = (bus.Imm[11:0] != 12'b0);
                encField = {bus.Imm[31:12], 12'b0};
                encMask  = 32'hFFFF_F000;
            end
            `EXT_OP_J: begin
                encErr   = !fits21 || bus.Imm[0];
                encField = {bus.Imm[20], bus.Imm[10:1], bus.Imm[11],
                            bus.Imm[19:12], 12'b0};
                encMask  = 32'hFFFF_F000;
            end
            default: begin
                encErr   = 1'b1;
                encField = '0;
                encMask  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            runQ    <= 1'b0;
            s1Valid <= 1'b0;
            s1Field <= '0;
            s1Mask  <= '0;
            s1Tmpl  <= '0;
            s1Err   <= 1'b0;
        end else begin
            runQ <= 1'b1;
            if (accept) begin
                s1Valid <= 1'b1;
                s1Field <= encField;
                s1Mask  <= encMask;
                s1Tmpl  <= bus.Tmpl;
                s1Err   <= encErr;
            end else if (s1Advance) begin
                s1Valid <= 1'b0;
            end
        end
    end

    // Template bits under the immediate are always cleared, even on error.
    assign s2Next = (s1Tmpl & ~s1Mask) | s1Field;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            outValidQ <= 1'b0;
            instQ     <= '0;
            errQ      <= 1'b0;
        end else if (s1Advance) begin
            outValidQ <= 1'b1;
            instQ     <= s2Next;
            errQ      <= s1Err;
        end else if (bus.out_ready) begin
            outValidQ <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            encCntQ <= '0;
            errCntQ <= '0;
        end else if (outXfer) begin
            encCntQ <= encCntQ + CNT_WIDTH'(1);
            if (errQ) begin
                errCntQ <= errCntQ + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.out_valid = outValidQ;
    assign bus.Inst      = instQ;
    assign bus.Err       = errQ;
    assign enc_cnt       = encCntQ;
    assign err_cnt       = errCntQ;

`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
    logic [`EXT_OP_LENGTH-1:0] s1ExtOp;
    logic [31:0]               s1Imm;
    logic                      rtQ;
    logic [31:0]               rtImm;

    // Same bit mapping as the immediate extender in the decode stage.
    function automatic logic [31:0] extractImm(input logic [`EXT_OP_LENGTH-1:0] op,
                                               input logic [31:0] i);
        case (op)
            `EXT_OP_I: extractImm = {{20{i[31]}}, i[31:20]};
            `EXT_OP_S: extractImm = {{20{i[31]}}, i[31:25], i[11:7]};
            `EXT_OP_B: extractImm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            `EXT_OP_U: extractImm = {i[31:12], 12'b0};
            `EXT_OP_J: extractImm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default:   extractImm = '0;
        endcase
    endfunction

    assign rtImm = extractImm(s1ExtOp, s2Next);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1ExtOp <= '0;
            s1Imm   <= '0;
        end else if (accept) begin
            s1ExtOp <= bus.ExtOp;
            s1Imm   <= bus.Imm;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rtQ <= 1'b0;
        end else if (s1Advance) begin
            rtQ <= !s1Err && (rtImm != s1Imm);
        end else if (bus.out_ready) begin
            rtQ <= 1'b0;
        end
    end

    assign rt_mismatch = rtQ;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rstn && outXfer && rtQ) begin
            $error("imm_encoder round-trip mismatch on Inst=%h", instQ);
        end
    end
`endif
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - self-checking bench for imm_encoder
`ifndef EXT_OP_LENGTH
`define EXT_OP_LENGTH 3
`endif
`ifndef EXT_OP_I
`define EXT_OP_I 3'd0
`endif
`ifndef EXT_OP_U
`define EXT_OP_U 3'd1
`endif
`ifndef EXT_OP_S
`define EXT_OP_S 3'd2
`endif
`ifndef EXT_OP_B
`define EXT_OP_B 3'd3
`endif
`ifndef EXT_OP_J
`define EXT_OP_J 3'd4
`endif

module tb_imm_encoder;
    localparam int CW   = 4;
    localparam int NVEC = 20;

    typedef struct {
        logic [`EXT_OP_LENGTH-1:0] op;
        logic [31:0]               imm;
        logic [31:0]               tmpl;
        logic [31:0]               inst;
        logic                      err;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [CW-1:0] enc_cnt;
    logic [CW-1:0] err_cnt;
`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
    logic rt_mismatch;
`endif

    imm_encoder_if bus();

    imm_encoder #(.CNT_WIDTH(CW)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .bus     (bus),
        .enc_cnt (enc_cnt),
        .err_cnt (err_cnt)
`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
        ,
        .rt_mismatch (rt_mismatch)
`endif
    );

    always #5 clk = ~clk;

    vec_t vecs[NVEC];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic done;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic setVec(input int i, input logic [`EXT_OP_LENGTH-1:0] op, input logic [31:0] imm,
                          input logic [31:0] tmpl, input logic [31:0] inst, input logic err);
        vecs[i].op   = op;
        vecs[i].imm  = imm;
        vecs[i].tmpl = tmpl;
        vecs[i].inst = inst;
        vecs[i].err  = err;
    endtask

    // Drive one request starting at posedge+1; returns at posedge+1 after the accept edge.
    task automatic send(input int idx);
        bit ok;
        exp_t e;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.ExtOp    = vecs[idx].op;
        bus.Imm      = vecs[idx].imm;
        bus.Tmpl     = vecs[idx].tmpl;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                e.inst = vecs[idx].inst;
                e.err  = vecs[idx].err;
                sb.push_back(e);
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout idx=%0d got=no_accept exp=accept", idx);
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 500 && sb.size() != 0; t++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got=%0d pending exp=0", sb.size());
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    // Scoreboard monitor: front entry must be presented (and held) until it transfers.
    always @(negedge clk) begin
        if (rstn && bus.out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out got=%h exp=none", bus.Inst);
            end else begin
                check("inst", bus.Inst, sb[0].inst);
                check("err", {31'b0, bus.Err}, {31'b0, sb[0].err});
`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
                check("rt_mismatch", {31'b0, rt_mismatch}, 32'd0);
`endif
                if (bus.out_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        setVec(0,  `EXT_OP_I, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0);
        setVec(1,  `EXT_OP_B, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0);
        setVec(2,  `EXT_OP_B, 32'h0000_0003, 32'h0000_0063, 32'h0000_0163, 1'b1);
        setVec(3,  `EXT_OP_J, 32'h0000_0800, 32'h0000_006F, 32'h0010_006F, 1'b0);
        setVec(4,  `EXT_OP_U, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 1'b0);
        setVec(5,  `EXT_OP_U, 32'h1234_5678, 32'h0000_0037, 32'h1234_5037, 1'b1);
        setVec(6,  `EXT_OP_S, 32'h0000_0000, 32'hFFFF_FFA3, 32'h01FF_F023, 1'b0);
        setVec(7,  `EXT_OP_S, 32'h0000_0800, 32'h0000_0023, 32'h8000_0023, 1'b1);
        setVec(8,  `EXT_OP_I, 32'h0000_07FF, 32'h0000_0013, 32'h7FF0_0013, 1'b0);
        setVec(9,  `EXT_OP_I, 32'hFFFF_F800, 32'h0000_0013, 32'h8000_0013, 1'b0);
        setVec(10, `EXT_OP_I, 32'hFFFF_F7FF, 32'h0000_0013, 32'h7FF0_0013, 1'b1);
        setVec(11, `EXT_OP_B, 32'h0000_0FFE, 32'h0000_0063, 32'h7E00_0FE3, 1'b0);
        setVec(12, `EXT_OP_B, 32'h0000_1000, 32'h0000_0063, 32'h8000_0063, 1'b1);
        setVec(13, `EXT_OP_B, 32'hFFFF_F000, 32'h0000_0063, 32'h8000_0063, 1'b0);
        setVec(14, `EXT_OP_J, 32'hFFF0_0000, 32'h0000_006F, 32'h8000_006F, 1'b0);
        setVec(15, `EXT_OP_J, 32'h0010_0000, 32'h0000_006F, 32'h8000_006F, 1'b1);
        setVec(16, `EXT_OP_J, 32'h0000_0003, 32'h0000_006F, 32'h0020_006F, 1'b1);
        setVec(17, `EXT_OP_S, 32'hFFFF_FFFF, 32'h0000_0023, 32'hFE00_0FA3, 1'b0);
        setVec(18, 3'd5,      32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678, 1'b1);
        setVec(19, `EXT_OP_J, 32'h000F_FFFE, 32'h0000_006F, 32'h7FFF_F06F, 1'b0);

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.ExtOp     = '0;
        bus.Imm       = '0;
        bus.Tmpl      = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_inst", bus.Inst, 32'd0);
        check("rst_err", {31'b0, bus.Err}, 32'd0);
        check("rst_enc_cnt", 32'(enc_cnt), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

        // Single request latency
        send(0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("lat_stage1", {31'b0, bus.out_valid}, 32'd0);
        @(negedge clk);
        check("lat_stage2", {31'b0, bus.out_valid}, 32'd1);
        @(negedge clk);
        check("lat_enc_cnt", 32'(enc_cnt), 32'd1);

        // Table pass, full throughput: 21 results total, 8 errors
        @(posedge clk);
        #1;
        for (int i = 0; i < NVEC; i++) send(i);
        bus.in_valid = 1'b0;
        drain();
        check("pass1_enc_cnt", 32'(enc_cnt), 32'd5);
        check("pass1_err_cnt", 32'(err_cnt), 32'd8);

        // Table pass with random backpressure: 41 results, 16 errors (both wrap)
        @(posedge clk);
        #1;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < NVEC; i++) send(i);
                bus.in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("pass2_enc_cnt", 32'(enc_cnt), 32'd9);
        check("pass2_err_cnt", 32'(err_cnt), 32'd0);

        // Reset with both stages full
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send(1);
        send(2);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("full_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("full_out_valid", {31'b0, bus.out_valid}, 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("midrst_enc_cnt", 32'(enc_cnt), 32'd0);
        check("midrst_err_cnt", 32'(err_cnt), 32'd0);
        check("midrst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        sb.delete();
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("rel_in_ready", {31'b0, bus.in_ready}, 32'd1);
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            check("no_stale", {31'b0, bus.out_valid}, 32'd0);
        end

        // Eight back-to-back with a 5-cycle output stall mid-stream
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < 8; i++) send(i);
                bus.in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                repeat (2) @(posedge clk);
                @(negedge clk);
                check("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
                check("stall_out_valid", {31'b0, bus.out_valid}, 32'd1);
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("burst_enc_cnt", 32'(enc_cnt), 32'd8);
        check("burst_err_cnt", 32'(err_cnt), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the immediate extender: packs a 32-bit signed/unsigned immediate into the RISC-V I/S/B/U/J immediate bit positions of an instruction template.
- Flags immediates the chosen format cannot represent.
- Two-stage valid/ready pipeline; used by the on-chip self-test instruction generator and the debug patch path to build instruction words before they enter IFU memory.

Parameters:
- CNT_WIDTH, 16, width of the encoded-instruction and error counters.

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request this cycle
- ExtOp  input  `EXT_OP_LENGTH  format select; uses the shared `EXT_OP_I/U/S/B/J codes
- Imm  input  32  immediate value in two's complement
- Tmpl  input  32  instruction template (opcode, rd, rs1, rs2, funct fields)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- Inst  output  32  encoded instruction
- Err  output  1  immediate not representable, or unknown ExtOp
- enc_cnt  output  CNT_WIDTH  number of results delivered
- err_cnt  output  CNT_WIDTH  number of delivered results with Err=1

Behaviour:
- Reset: asynchronous on rstn low. in_ready=0 while rstn low and 1 after release. out_valid, Inst, Err, enc_cnt and err_cnt are all 0.
- Handshakes:
  - Input accepted when in_valid && in_ready.
  - Output transfers when out_valid && out_ready.
  - Inst and Err hold stable while out_valid && !out_ready.
- Stage 1 (registered on accept): computes the range check and the scattered immediate field.
  - I: Imm in [-2048, 2047]; field = Imm[11:0] into Inst[31:20].
  - S: Imm in [-2048, 2047]; Imm[11:5] into Inst[31:25], Imm[4:0] into Inst[11:7].
  - B: Imm in [-4096, 4094] and Imm[0]=0; Imm[12] into [31], Imm[10:5] into [30:25], Imm[4:1] into [11:8], Imm[11] into [7].
  - U: Imm[11:0]=0; Imm[31:12] into Inst[31:12].
  - J: Imm in [-1048576, 1048574] and Imm[0]=0; Imm[20] into [31], Imm[10:1] into [30:21], Imm[11] into [20], Imm[19:12] into [19:12].
  - Unknown ExtOp: Err=1, field=0, mask=0.
- Stage 2 (output register): Inst = (Tmpl & ~mask) | field, where mask covers exactly that format's immediate bits. Template bits in immediate positions are always cleared.
- On Err=1, Inst still carries the truncated encoding. Truncation is defined by the bit mapping above.
- Latency: 2 cycles from accept to out_valid when there is no backpressure. Throughput is 1 result per cycle.
- Stall rule:
  - Stage 1 advances when stage 2 is empty or transferring this cycle.
  - in_ready = !s1_valid || s1_advance.
  - Full backpressure holds both stages, with in_ready=0.
- Simultaneous transfer: an input accept, a stage advance and an output transfer in the same cycle keep full throughput with no bubble and no loss.
- Counters:
  - enc_cnt increments on each output transfer.
  - err_cnt increments on each output transfer with Err=1.
  - Both wrap modulo 2^CNT_WIDTH.
- Reset mid-operation drops all in-flight requests, clears the counters and forces out_valid=0 immediately.

Optional Feature:
- Macro: IMM_ENC_ROUNDTRIP_CHECK_EN.
- When defined:
  - Stage 2 re-extracts the immediate from Inst using the extender's bit mapping.
  - When Err=0, the re-extracted value is compared with the registered Imm.
  - A mismatch raises an extra output port rt_mismatch (1 bit, registered, aligned with out_valid, reset 0).
  - A simulation-only $error fires on the transferred beat.
- When undefined: the port and logic are absent.

Test Plan:
- Tmpl=0x00000013, ExtOp=I, Imm=0xFFFFFFFF, out_ready=1 -> 2 cycles later Inst=0xFFF00013, Err=0, enc_cnt=1.
- Tmpl=0x00000063, ExtOp=B, Imm=0xFFFFFFFC -> Inst=0xFE000EE3, Err=0. Same with Imm=0x00000003 -> Err=1, err_cnt=1.
- Tmpl=0x0000006F, ExtOp=J, Imm=0x00000800 -> Inst=0x0010006F. Tmpl=0x00000037, ExtOp=U, Imm=0x12345000 -> Inst=0x12345037. Imm=0x12345678 -> Err=1.
- Tmpl=0xFFFFFFA3 (all immediate bits set), ExtOp=S, Imm=0 -> Inst=0x01FFF023 (template immediate bits cleared). ExtOp=S, Imm=2048 -> Err=1.
- Back-to-back 8 requests with out_ready held low 5 cycles mid-stream:
  - in_ready drops after two requests are held.
  - Inst/Err stable while stalled.
  - All 8 results delivered in order.
  - enc_cnt=8.
- rstn pulsed low with both stages full -> out_valid=0 and counters 0 immediately, in_ready=0 during reset. After release, in_ready=1 and no stale result emerges.
